// File: rtl/crc_frame_checker.sv
// ---------------------------------------------------------------------------
// crc_frame_checker
//
// Receive side of the serial CRC link. A frame is DATA_WIDTH payload bits
// followed by CRC_WIDTH check bits, both MSB-first. The payload is run
// through a bit-serial LFSR and the result is compared against the received
// check bits. When a frame completes, the recovered word, both CRC values
// and a pass/fail flag are published. They then hold until the next
// completed frame or a reset.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESET       in   synchronous active-high reset
//   FRAME_START in   one-cycle pulse that begins (or restarts) a frame
//   BIT_VALID   in   BIT_IN is valid this cycle
//   BIT_IN      in   serial frame bit, MSB-first
//   DATA_OUT    out  [DATA_WIDTH] payload of the last completed frame
//   CRC_RX      out  [CRC_WIDTH]  received check bits of the last frame
//   CRC_CALC    out  [CRC_WIDTH]  computed CRC of the last frame
//   CRC_OK      out  CRC_RX == CRC_CALC for the last frame
//   FRAME_DONE  out  one-cycle pulse while a frame publishes
//   BUSY        out  high while receiving data or check bits
// ---------------------------------------------------------------------------
module crc_frame_checker #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLY       = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT       = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FRAME_START,
  input  logic                  BIT_VALID,
  input  logic                  BIT_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic [CRC_WIDTH-1:0]  CRC_RX,
  output logic [CRC_WIDTH-1:0]  CRC_CALC,
  output logic                  CRC_OK,
  output logic                  FRAME_DONE,
  output logic                  BUSY
);

  localparam int MAX_W = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CRC_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CRC_WIDTH-1:0]  r_crc;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CRC_WIDTH-1:0]  r_chk;

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [CRC_WIDTH-1:0]  r_crc_rx;
  logic [CRC_WIDTH-1:0]  r_crc_calc;
  logic                  r_crc_ok;
  logic                  r_frame_done;
  logic                  r_busy;

  logic                  w_fb;
  logic [CRC_WIDTH-1:0]  w_crc_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [CRC_WIDTH-1:0]  w_chk_next;

  // One LFSR step: shift left, and fold in the polynomial when the bit
  // leaving the top differs from the incoming data bit.
  assign w_fb          = r_crc[CRC_WIDTH-1] ^ BIT_IN;
  assign w_crc_next[0] = w_fb & POLY[0];

  genvar gi;
  generate
    for (gi = 1; gi < CRC_WIDTH; gi++) begin : g_lfsr
      assign w_crc_next[gi] = r_crc[gi-1] ^ (w_fb & POLY[gi]);
    end
  endgenerate

  assign w_data_next = {r_data[DATA_WIDTH-2:0], BIT_IN};
  // Includes the bit being accepted this cycle, so the last check bit can
  // be compared and published on the same edge that accepts it.
  assign w_chk_next  = {r_chk[CRC_WIDTH-2:0], BIT_IN};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_crc        <= '0;
      r_data       <= '0;
      r_chk        <= '0;
      r_data_out   <= '0;
      r_crc_rx     <= '0;
      r_crc_calc   <= '0;
      r_crc_ok     <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (FRAME_START) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_crc   <= INIT;
            r_busy  <= 1'b1;
          end
        end

        S_DATA: begin
          // A restart drops the partial frame; any bit this cycle is lost.
          if (FRAME_START) begin
            r_cnt <= '0;
            r_crc <= INIT;
          end else if (BIT_VALID) begin
            r_data <= w_data_next;
            r_crc  <= w_crc_next;
            if (r_cnt == DATA_LAST) begin
              r_state <= S_CHECK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_CHECK: begin
          if (FRAME_START) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_crc   <= INIT;
          end else if (BIT_VALID) begin
            r_chk <= w_chk_next;
            if (r_cnt == CHK_LAST) begin
              // Publish on this edge so the outputs and FRAME_DONE are
              // visible for the single cycle spent in DONE.
              r_state      <= S_DONE;
              r_cnt        <= '0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_data_out   <= r_data;
              r_crc_rx     <= w_chk_next;
              r_crc_calc   <= r_crc;
              r_crc_ok     <= (w_chk_next == r_crc);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          // Back-to-back frames: a start pulse here goes straight to DATA.
          if (FRAME_START) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_crc   <= INIT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA_OUT   = r_data_out;
  assign CRC_RX     = r_crc_rx;
  assign CRC_CALC   = r_crc_calc;
  assign CRC_OK     = r_crc_ok;
  assign FRAME_DONE = r_frame_done;
  assign BUSY       = r_busy;

endmodule
